// File: rtl/spi_master_rx_if.sv
// spi_master_rx_if: request, word return and SPI pin bundle.
// master is the spi_master_rx side, slave is the sequencer/pin side.
interface spi_master_rx_if #(
  parameter int BITS = 12
);
  logic            start;
  logic            miso;
  logic [BITS-1:0] data;
  logic            valid;
  logic            busy;
  logic            sck;
  logic            cs;

  modport master (
    input  start,
    input  miso,
    output data,
    output valid,
    output busy,
    output sck,
    output cs
  );

  modport slave (
    output start,
    output miso,
    input  data,
    input  valid,
    input  busy,
    input  sck,
    input  cs
  );
endinterface

// File: rtl/spi_master_rx.sv
// spi_master_rx: receive-only SPI master, one BITS-wide word per start.
// Define SPI_MASTER_RX_INVERT_EN to sample !miso (inverting level shifter).
module spi_master_rx #(
  parameter int BITS      = 12,
  parameter int DIV       = 2,
  parameter int CPOL      = 1,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset,
  spi_master_rx_if.master   bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(BITS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS);
  localparam logic          SCK_IDLE = (CPOL != 0);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LEAD,
    TRAIL,
    GUARD
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [BW-1:0]   bit_cnt_q;
  logic [BITS-1:0] sr_q;
  logic [BITS-1:0] sr_d;
  logic [BITS-1:0] data_q;
  logic            valid_q;
  logic            busy_q;
  logic            sck_q;
  logic            cs_q;
  logic            miso_bit;
  logic            cnt_done;

`ifdef SPI_MASTER_RX_INVERT_EN
  assign miso_bit = ~bus.miso;
`else
  assign miso_bit = bus.miso;
`endif

  // Every state change happens on cnt_done, so wrapping here is the reload.
  assign cnt_done = (cnt_q == CNT_LAST);
  assign cnt_d    = cnt_done ? '0 : cnt_q + 1'b1;

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign sr_d = {miso_bit, sr_q[BITS-1:1]};
    end else begin : g_msb
      assign sr_d = {sr_q[BITS-2:0], miso_bit};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      sck_q     <= SCK_IDLE;
      cs_q      <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= SETUP;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            cs_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        SETUP: begin
          cnt_q <= cnt_d;
          if (cnt_done) begin
            state_q <= LEAD;
            sck_q   <= ~SCK_IDLE;
          end
        end
        LEAD: begin
          cnt_q <= cnt_d;
          // miso is captured on the edge that returns sck to idle.
          if (cnt_done) begin
            state_q   <= TRAIL;
            sck_q     <= SCK_IDLE;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        TRAIL: begin
          cnt_q <= cnt_d;
          if (cnt_done) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= GUARD;
              cs_q    <= 1'b1;
              data_q  <= sr_q;
              valid_q <= 1'b1;
            end else begin
              state_q <= LEAD;
              sck_q   <= ~SCK_IDLE;
            end
          end
        end
        GUARD: begin
          cnt_q <= cnt_d;
          if (cnt_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.sck   = sck_q;
  assign bus.cs    = cs_q;

endmodule

// File: tb/tb_spi_master_rx.sv
// tb_spi_master_rx: three configurations of spi_master_rx, slave models
// feeding miso, and a scoreboard checking words and timing on each valid.
module tb_spi_master_rx;
  localparam int N  = 3;
  localparam int QD = 64;

  function automatic int f_bits(int d);
    return (d == 2) ? 2 : 12;
  endfunction
  function automatic int f_div(int d);
    return (d == 2) ? 1 : 2;
  endfunction
  function automatic int f_cpol(int d);
    return (d == 2) ? 0 : 1;
  endfunction
  function automatic int f_lsb(int d);
    return (d == 1) ? 1 : 0;
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_v [N];
  logic [11:0] tx_mem  [N][QD];
  logic [11:0] exp_mem [N][QD];
  int          tx_wr   [N];
  int          exp_wr  [N];
  wire  [11:0] data_v  [N];
  wire         valid_v [N];
  wire         busy_v  [N];
  wire         sck_v   [N];
  wire         cs_v    [N];
  wire  [31:0] exp_rd_v [N];
  wire  [31:0] csf_v    [N];
  longint      cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] got,
                                logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  // Expected word from the transmitted stream (stream is MSB-first).
  function automatic logic [11:0] model(logic [11:0] w, int b, int lsb);
    logic [11:0] r;
    logic        s;
    r = '0;
    for (int i = 0; i < b; i++) begin
      s = w[b-1-i];
`ifdef SPI_MASTER_RX_INVERT_EN
      s = ~s;
`endif
      if (lsb != 0) r[i] = s;
      else r[b-1-i] = s;
    end
    return r;
  endfunction

  for (genvar g = 0; g < N; g++) begin : gd
    localparam int   B = f_bits(g);
    localparam int   D = f_div(g);
    localparam logic C = (f_cpol(g) != 0);

    spi_master_rx_if #(.BITS(B)) ifc ();

    spi_master_rx #(
      .BITS(B),
      .DIV(D),
      .CPOL(f_cpol(g)),
      .LSB_FIRST(f_lsb(g))
    ) dut (
      .clk(clk),
      .reset(reset),
      .bus(ifc.master)
    );

    logic        miso = 1'b0;
    logic [11:0] word = '0;
    int          idx = 0;
    int          tx_rd = 0;
    int          exp_rd = 0;
    int          csf = 0;
    int          lead_n = 0;
    longint      e0 = 0;
    logic        cs_p = 1'b1;
    logic        sck_p = C;
    logic        val_p = 1'b0;
    logic        busy_p = 1'b0;
    logic        pend;

    assign ifc.start   = start_v[g];
    assign ifc.miso    = miso;
    assign data_v[g]   = 12'(ifc.data);
    assign valid_v[g]  = ifc.valid;
    assign busy_v[g]   = ifc.busy;
    assign sck_v[g]    = ifc.sck;
    assign cs_v[g]     = ifc.cs;
    assign exp_rd_v[g] = 32'(exp_rd);
    assign csf_v[g]    = 32'(csf);

    // Slave: load a word on cs fall, shift out on each leading sck edge.
    always @(negedge ifc.cs) begin
      word = tx_mem[g][tx_rd % QD];
      tx_rd++;
      idx = 0;
    end
    always @(ifc.sck) begin
      if (!ifc.cs && ifc.sck != C && idx < B) begin
        miso = word[B-1-idx];
        idx++;
      end
    end

    always @(negedge clk) begin
      if (cs_p && !ifc.cs) begin
        e0 = cyc;
        lead_n = 0;
        csf++;
      end
      if (!ifc.cs && sck_p == C && ifc.sck != C) lead_n++;
      if (!cs_p && ifc.cs && !reset)
        check($sformatf("d%0d_sck_idle_at_cs_rise", g),
              64'(ifc.sck), 64'(C));
      if (ifc.valid) begin
        check($sformatf("d%0d_valid_single", g), 64'(val_p), 64'(0));
        pend = (exp_wr[g] > exp_rd);
        check($sformatf("d%0d_valid_expected", g), 64'(pend), 64'(1));
        if (pend) begin
          check($sformatf("d%0d_data", g), 64'(ifc.data),
                64'(exp_mem[g][exp_rd % QD]));
          exp_rd++;
          check($sformatf("d%0d_valid_time", g), 64'(cyc - e0),
                64'((2 * B + 1) * D));
          check($sformatf("d%0d_sck_leads", g), 64'(lead_n), 64'(B));
        end
      end
      if (busy_p && !ifc.busy && !reset)
        check($sformatf("d%0d_busy_fall_time", g), 64'(cyc - e0),
              64'((2 * B + 2) * D));
      cs_p   = ifc.cs;
      sck_p  = ifc.sck;
      val_p  = ifc.valid;
      busy_p = ifc.busy;
    end
  end

  task automatic push(int d, logic [11:0] w, bit chk);
    logic [11:0] m;
    m = w & 12'((1 << f_bits(d)) - 1);
    tx_mem[d][tx_wr[d] % QD] = m;
    tx_wr[d]++;
    if (chk) begin
      exp_mem[d][exp_wr[d] % QD] = model(m, f_bits(d), f_lsb(d));
      exp_wr[d]++;
    end
  endtask

  task automatic pulse_start(int d);
    @(negedge clk) start_v[d] = 1'b1;
    @(negedge clk) start_v[d] = 1'b0;
  endtask

  task automatic wait_idle(int d, string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      done = !busy_v[d];
    end
    check({name, "_idle_timeout"}, 64'(done), 64'(1));
  endtask

  task automatic run(int d, logic [11:0] w, string name);
    push(d, w, 1'b1);
    pulse_start(d);
    wait_idle(d, name);
  endtask

  task automatic check_reset_vals(string name);
    for (int d = 0; d < N; d++) begin
      check($sformatf("%s_d%0d_cs", name, d), 64'(cs_v[d]), 64'(1));
      check($sformatf("%s_d%0d_sck", name, d), 64'(sck_v[d]),
            64'(f_cpol(d)));
      check($sformatf("%s_d%0d_valid", name, d), 64'(valid_v[d]), 64'(0));
      check($sformatf("%s_d%0d_busy", name, d), 64'(busy_v[d]), 64'(0));
      check($sformatf("%s_d%0d_data", name, d), 64'(data_v[d]), 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int     c0;
    longint t1;
    longint t2;
    for (int d = 0; d < N; d++) begin
      start_v[d] = 1'b0;
      tx_wr[d]   = 0;
      exp_wr[d]  = 0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    #1 reset = 1'b0;

    run(0, 12'hA5C, "d0_a5c");
    for (int i = 0; i < 16; i++) run(0, 12'($urandom), "d0_rand");

    // Starts during a transaction and in GUARD must be dropped.
    c0 = int'(csf_v[0]);
    push(0, 12'($urandom), 1'b1);
    pulse_start(0);
    repeat (9) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    repeat (40) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    wait_idle(0, "d0_ignore");
    repeat (5) @(negedge clk);
    check("d0_ignored_starts", 64'(int'(csf_v[0]) - c0), 64'(1));

    // start held high: back-to-back with the full guard in between.
    push(0, 12'($urandom), 1'b1);
    push(0, 12'($urandom), 1'b1);
    c0 = int'(csf_v[0]);
    t1 = -1;
    t2 = -1;
    @(negedge clk) start_v[0] = 1'b1;
    for (int i = 0; i < 400 && t2 < 0; i++) begin
      @(negedge clk);
      if (int'(csf_v[0]) - c0 == 1 && t1 < 0) t1 = cyc;
      if (int'(csf_v[0]) - c0 == 2) t2 = cyc;
    end
    start_v[0] = 1'b0;
    check("d0_held_start_gap", 64'(t2 - t1),
          64'((2 * f_bits(0) + 2) * f_div(0) + 1));
    wait_idle(0, "d0_held");

    // Reset in the middle of a word: no valid, everything back to idle.
    push(0, 12'($urandom), 1'b0);
    pulse_start(0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("abort");
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    run(0, 12'($urandom), "d0_after_abort");

    run(1, 12'hA5C, "d1_a5c");
    for (int i = 0; i < 10; i++) run(1, 12'($urandom), "d1_rand");

    run(2, 12'h002, "d2_b10");
    for (int i = 0; i < 10; i++) run(2, 12'($urandom), "d2_rand");

    repeat (10) @(negedge clk);
    for (int d = 0; d < N; d++)
      check($sformatf("d%0d_all_words_seen", d), 64'(exp_rd_v[d]),
            64'(exp_wr[d]));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
